// File: rtl/datamem_arbiter_if.sv
// Requester-side bundle for the data memory arbiter: request handshake plus
// the one-cycle response pulse. One instance per requester.
interface datamem_arbiter_if;
  logic        valid;
  logic        ready;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output valid, we, addr, wdata, wstrb,
    input  ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  valid, we, addr, wdata, wstrb,
    output ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/datamem_arbiter.sv
// Round-robin arbiter sharing one word-wide data memory between the core LSU
// (req0) and DMA/debug (req1); sub-word stores become read-modify-write.
module datamem_arbiter #(
  parameter int unsigned MEM_SIZE = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  datamem_arbiter_if.slave    req0,
  datamem_arbiter_if.slave    req1,
  output logic [31:0]         mem_ra_o,
  output logic [31:0]         mem_wa_o,
  output logic [31:0]         mem_wd_o,
  output logic                mem_we_o,
  input  logic [31:0]         mem_rd_i
);

  localparam logic [31:0] LAST_WORD = 32'(MEM_SIZE - 4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MERGE
  } state_e;

  state_e      state_q;
  logic        last_q;
  logic        port_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] wd_q;
  logic [3:0]  wstrb_q;
  logic        mem_we_q;
  logic        resp0_valid_q, resp1_valid_q;
  logic        resp0_err_q,   resp1_err_q;
  logic [31:0] resp0_rdata_q, resp1_rdata_q;

  logic        gnt_port;
  logic        ready0, ready1, accept;
  logic        sel_we;
  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  sel_wstrb;
  logic        sel_oor, oor_q, partial_q;
  logic        go_merge, resp_fire, resp_err;
  logic [31:0] resp_rdata, merged;

  // NOTE: every signal assigned in always_comb gets a value at the top of the
  // block first; a path that skips an assignment would otherwise infer a latch.
  always_comb begin
    gnt_port  = (req0.valid && req1.valid) ? ~last_q : req1.valid;
    ready0    = rst_n && (state_q == S_IDLE) && req0.valid && !gnt_port;
    ready1    = rst_n && (state_q == S_IDLE) && req1.valid &&  gnt_port;
    accept    = ready0 || ready1;

    sel_we    = gnt_port ? req1.we    : req0.we;
    sel_addr  = (gnt_port ? req1.addr : req0.addr) & 32'hFFFF_FFFC;
    sel_wdata = gnt_port ? req1.wdata : req0.wdata;
    sel_wstrb = gnt_port ? req1.wstrb : req0.wstrb;
    sel_oor   = sel_addr > LAST_WORD;

    oor_q     = addr_q > LAST_WORD;
    partial_q = (wstrb_q != 4'h0) && (wstrb_q != 4'hF);

    // Old lanes come from the EXEC-cycle read, new lanes from the request.
    merged = mem_rd_i;
    for (int i = 0; i < 4; i++) begin
      if (wstrb_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end

    go_merge   = (state_q == S_EXEC) && !oor_q && we_q && partial_q;
    resp_fire  = ((state_q == S_EXEC) && !go_merge) || (state_q == S_MERGE);
    resp_err   = (state_q == S_EXEC) && oor_q;
    resp_rdata = ((state_q == S_EXEC) && !oor_q && !we_q) ? mem_rd_i : 32'h0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      last_q        <= 1'b1;
      port_q        <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wd_q          <= '0;
      wstrb_q       <= '0;
      mem_we_q      <= 1'b0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_err_q   <= 1'b0;
      resp1_err_q   <= 1'b0;
      resp0_rdata_q <= '0;
      resp1_rdata_q <= '0;
    end else begin
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      mem_we_q      <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            port_q   <= gnt_port;
            last_q   <= gnt_port;
            we_q     <= sel_we;
            addr_q   <= sel_addr;
            wdata_q  <= sel_wdata;
            wd_q     <= sel_wdata;
            wstrb_q  <= sel_wstrb;
            // Full-word stores commit in EXEC, so the enable is raised here.
            mem_we_q <= sel_we && (sel_wstrb == 4'hF) && !sel_oor;
            state_q  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (go_merge) begin
            wd_q     <= merged;
            mem_we_q <= 1'b1;
            state_q  <= S_MERGE;
          end else begin
            state_q  <= S_IDLE;
          end
        end
        S_MERGE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase

      if (resp_fire) begin
        if (port_q) begin
          resp1_valid_q <= 1'b1;
          resp1_err_q   <= resp_err;
          resp1_rdata_q <= resp_rdata;
        end else begin
          resp0_valid_q <= 1'b1;
          resp0_err_q   <= resp_err;
          resp0_rdata_q <= resp_rdata;
        end
      end
    end
  end

  assign req0.ready      = ready0;
  assign req1.ready      = ready1;
  assign req0.resp_valid = resp0_valid_q;
  assign req0.resp_rdata = resp0_rdata_q;
  assign req0.resp_err   = resp0_err_q;
  assign req1.resp_valid = resp1_valid_q;
  assign req1.resp_rdata = resp1_rdata_q;
  assign req1.resp_err   = resp1_err_q;

  assign mem_ra_o = addr_q;
  assign mem_wa_o = addr_q;
  assign mem_wd_o = wd_q;
  assign mem_we_o = mem_we_q;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Scoreboard bench for datamem_arbiter: drivers push expected responses and
// memory writes from a byte-level memory model; a negedge monitor compares.
module tb_datamem_arbiter;

  localparam int MEM_SIZE = 4096;
  localparam int WORDS    = MEM_SIZE / 4;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } resp_t;

  typedef struct {
    int          cyc;
    logic [31:0] wa;
    logic [31:0] wd;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem_ra, mem_wa, mem_wd, mem_rd;
  logic        mem_we;

  logic [31:0] dmem    [WORDS];
  logic [7:0]  ref_mem [MEM_SIZE];

  resp_t rq[$];
  wr_t   wq[$];
  int    cyc = 0;
  int    free_cyc = 0;
  int    model_last = 1;
  int    checks = 0;
  int    errors = 0;

  datamem_arbiter_if r0();
  datamem_arbiter_if r1();

  datamem_arbiter #(.MEM_SIZE(MEM_SIZE)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (r0),
    .req1     (r1),
    .mem_ra_o (mem_ra),
    .mem_wa_o (mem_wa),
    .mem_wd_o (mem_wd),
    .mem_we_o (mem_we),
    .mem_rd_i (mem_rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory behind the arbiter: combinational read, write on the rising edge.
  assign mem_rd = (mem_ra < 32'(MEM_SIZE)) ? dmem[mem_ra[11:2]] : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    if (rst_n && mem_we && (mem_wa < 32'(MEM_SIZE))) dmem[mem_wa[11:2]] <= mem_wd;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_word(input int a);
    return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
  endfunction

  task automatic ref_set_word(input int a, input logic [31:0] w);
    for (int b = 0; b < 4; b++) ref_mem[a+b] = w[8*b +: 8];
  endtask

  // Reference behaviour of one accepted request, evaluated at the accept cycle t.
  task automatic model_accept(input int p, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] wstrb, input int t);
    logic [31:0] a;
    resp_t       r;
    wr_t         w;
    int          lat;
    a       = addr & 32'hFFFF_FFFC;
    r.port  = p;
    r.rdata = 32'h0;
    r.err   = 1'b0;
    lat     = 2;
    if (a > 32'(MEM_SIZE - 4)) begin
      r.err = 1'b1;
    end else if (!we) begin
      r.rdata = ref_word(int'(a));
    end else if (wstrb != 4'h0) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) ref_mem[int'(a)+b] = wdata[8*b +: 8];
      end
      lat  = (wstrb == 4'hF) ? 2 : 3;
      w.cyc = t + lat - 1;
      w.wa  = a;
      w.wd  = ref_word(int'(a));
      wq.push_back(w);
    end
    r.cyc = t + lat;
    rq.push_back(r);
    free_cyc   = t + lat;
    model_last = p;
  endtask

  // Called just after a rising edge; returns just after the accept edge.
  task automatic issue(input int p, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
    logic got;
    int   other;
    got = 1'b0;
    if (p == 0) begin
      r0.we = we; r0.addr = addr; r0.wdata = wdata; r0.wstrb = wstrb; r0.valid = 1'b1;
    end else begin
      r1.we = we; r1.addr = addr; r1.wdata = wdata; r1.wstrb = wstrb; r1.valid = 1'b1;
    end
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clk);
      if ((p == 0) ? r0.ready : r1.ready) begin
        got   = 1'b1;
        other = (p == 0) ? int'(r1.valid) : int'(r0.valid);
        if (other != 0) check("rr_grant", p, 1 - model_last);
        check("ready_early", 32'(cyc >= free_cyc), 1);
        model_accept(p, we, addr, wdata, wstrb, cyc);
      end
    end
    if (!got) check("ready_timeout", 32'(got), 1);
    @(posedge clk);
    #1;
    if (p == 0) r0.valid = 1'b0;
    else        r1.valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    rq.delete();
    wq.delete();
    model_last = 1;
    #1;
    check("rst_ready0", r0.ready, 0);
    check("rst_ready1", r1.ready, 0);
    check("rst_resp0_valid", r0.resp_valid, 0);
    check("rst_resp1_valid", r1.resp_valid, 0);
    check("rst_resp0_rdata", r0.resp_rdata, 0);
    check("rst_mem_we", mem_we, 0);
    repeat (n) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    free_cyc = cyc;
  endtask

  task automatic gap();
    int n;
    n = $urandom_range(0, 3);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic random_stream(input int p, input int count);
    logic [31:0] addr;
    int          sel;
    for (int i = 0; i < count; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      addr = 32'h0FF0 + 32'($urandom_range(0, 31));
      else if (sel == 1) addr = $urandom;
      else               addr = 32'($urandom_range(0, 63));
      issue(p, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)));
      gap();
    end
  endtask

  // Monitor: compares every DUT output event against the scoreboard queues.
  always @(negedge clk) begin
    resp_t e;
    logic  exp_we, rv, re;
    logic [31:0] rd;
    if (rst_n) begin
      if (r0.ready || r1.ready) begin
        check("one_ready", 32'(r0.ready & r1.ready), 0);
        check("ready_no_valid", 32'((r0.ready & ~r0.valid) | (r1.ready & ~r1.valid)), 0);
      end
      if ((r0.valid || r1.valid) && (cyc >= free_cyc))
        check("stall", 32'(r0.ready | r1.ready), 1);

      while (wq.size() > 0 && wq[0].cyc < cyc) void'(wq.pop_front());
      exp_we = (wq.size() > 0) && (wq[0].cyc == cyc);
      check("mem_we", mem_we, exp_we);
      if (exp_we) begin
        if (mem_we) begin
          check("mem_wa", mem_wa, wq[0].wa);
          check("mem_wd", mem_wd, wq[0].wd);
        end
        void'(wq.pop_front());
      end

      for (int p = 0; p < 2; p++) begin
        rv = (p == 0) ? r0.resp_valid : r1.resp_valid;
        rd = (p == 0) ? r0.resp_rdata : r1.resp_rdata;
        re = (p == 0) ? r0.resp_err   : r1.resp_err;
        if (rv) begin
          if (rq.size() == 0) begin
            check("resp_pending", 32'(rq.size()), 1);
          end else begin
            e = rq.pop_front();
            check("resp_port", p, e.port);
            check("resp_cycle", cyc, e.cyc);
            check("resp_rdata", rd, e.rdata);
            check("resp_err", re, e.err);
          end
        end
      end
      if (rq.size() > 0 && rq[0].cyc < cyc) begin
        check("resp_missing", cyc, rq[0].cyc);
        void'(rq.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w;
    r0.valid = 1'b0; r0.we = 1'b0; r0.addr = '0; r0.wdata = '0; r0.wstrb = '0;
    r1.valid = 1'b0; r1.we = 1'b0; r1.addr = '0; r1.wdata = '0; r1.wstrb = '0;
    for (int i = 0; i < WORDS; i++) begin
      w       = $urandom;
      dmem[i] = w;
      ref_set_word(4 * i, w);
    end
    do_reset(3);

    // Full-word write then read-back.
    issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0);

    // Read-modify-write of one byte lane, then read-back.
    issue(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF);
    issue(0, 1'b1, 32'h20, 32'h0000_AA00, 4'b0010);
    issue(0, 1'b0, 32'h20, 32'h0, 4'h0);

    // Range boundary: first word past the end, last word, far out.
    issue(0, 1'b1, 32'h1000, 32'h5555_5555, 4'hF);
    issue(0, 1'b0, 32'h0FFC, 32'h0, 4'h0);
    issue(1, 1'b0, 32'h1004, 32'h0, 4'h0);

    // Empty strobe leaves memory untouched.
    issue(1, 1'b1, 32'h10, 32'h1234_5678, 4'h0);
    issue(1, 1'b0, 32'h13, 32'h0, 4'h0);

    // Both ports hold valid continuously.
    fork
      for (int i = 0; i < 8; i++) issue(0, 1'b0, 32'($urandom_range(0, 63)), 32'h0, 4'h0);
      for (int i = 0; i < 8; i++) issue(1, 1'b0, 32'($urandom_range(0, 63)), 32'h0, 4'h0);
    join

    fork
      random_stream(0, 120);
      random_stream(1, 120);
    join

    // Reset while a partial write sits in MERGE: the write and response are dropped.
    issue(0, 1'b1, 32'h30, 32'hCAFE_F00D, 4'hF);
    issue(0, 1'b1, 32'h30, 32'h00BB_0000, 4'b0100);
    @(posedge clk);
    #1;
    check("merge_we", mem_we, 1);
    do_reset(3);
    ref_set_word(32'h30, 32'hCAFE_F00D);
    fork
      issue(0, 1'b0, 32'h30, 32'h0, 4'h0);
      issue(1, 1'b0, 32'h10, 32'h0, 4'h0);
    join

    for (int k = 0; k < 40 && rq.size() > 0; k++) @(negedge clk);
    @(posedge clk);
    #1;
    check("drain_empty", 32'(rq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/datamem_arbiter.md
Name: datamem_arbiter

Overview:
- Shares the single byte-addressed data memory (one write port, combinational word reads) between two requesters: port 0 is the core load/store unit and port 1 is DMA/debug.
- Round-robin arbitration with valid/ready request handshake and a one-cycle response pulse.
- Sub-word stores, selected by byte strobes, are performed as a read-modify-write, because the memory only writes whole words.
- Sits between the requesters and the memory's ra/wa/wd/we/rd pins.

Parameters:
- MEM_SIZE, 4096, memory size in bytes; must be a multiple of 4.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- reqN_valid  input  1  request present (N = 0, 1)
- reqN_ready  output  1  request accepted this cycle
- reqN_we  input  1  1 = write, 0 = read
- reqN_addr  input  32  byte address; bits [1:0] ignored (word aligned)
- reqN_wdata  input  32  write data, little-endian byte lanes
- reqN_wstrb  input  4  byte-lane write enables (lane i = wdata[8i+7:8i])
- respN_valid  output  1  one-cycle response pulse
- respN_rdata  output  32  read data; 0 for writes and errors
- respN_err  output  1  out-of-range address, qualified by respN_valid
- mem_ra  output  32  memory read address
- mem_wa  output  32  memory write address
- mem_wd  output  32  memory write data
- mem_we  output  1  memory write enable
- mem_rd  input  32  memory read data (combinational from mem_ra)

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE; last-served pointer=1, so port 0 wins the first tie.
  - All resp*/mem_we/reqN_ready=0; internal request registers cleared.
  - An in-flight request is dropped silently: no response, no further memory write.
- Arbitration (IDLE only):
  - grant = the sole valid port; if both are valid, the port != last-served.
  - reqN_ready = (state==IDLE) & grant==N. This is combinational from valid.
  - Never both ready. Ready is 0 in every state except IDLE.
- Accept cycle T (valid & ready):
  - Latch we, addr with [1:0] forced to 00, wdata, wstrb and port id.
  - Update last-served. Go to EXEC.
- Range check: an address is out of range if word addr > MEM_SIZE-4.
  - The request goes EXEC -> IDLE with no memory access (mem_we stays 0).
  - resp err=1, rdata=0.
- EXEC (T+1):
  - Read: mem_ra=addr; capture mem_rd into respN_rdata. respN_valid=1 at T+2.
  - Write, wstrb=1111: mem_we=1, mem_wa=addr, mem_wd=wdata. Commits at the T+1 edge; resp at T+2.
  - Write, wstrb=0000: no memory write; resp at T+2.
  - Write, partial strobe: mem_ra=addr; capture mem_rd into merge register; go to MERGE.
- MERGE (T+2):
  - mem_we=1, mem_wa=addr.
  - mem_wd lane i = wstrb[i] ? wdata lane i : old lane i.
  - resp at T+3.
- Responses:
  - respN_valid is registered and high exactly one cycle, only on the requesting port; the other port's resp stays 0.
  - During the response cycle the state is already IDLE, so a new accept may occur in the same cycle.
- Throughput and latency:
  - Throughput is one request per 2 cycles, or 3 for partial writes.
  - Read latency is 2 cycles from accept.
- Outputs outside access cycles:
  - mem_we=0 outside EXEC (full-word write) and MERGE.
  - mem_ra/mem_wa/mem_wd hold the latched addr/data (don't-care when not used).
- Read data: rdata is valid only with resp_valid; it holds its last value otherwise.
- Non-held request: if a requester drops valid before ready, nothing is latched; no requirement is placed on requesters.
- Ordering: same-port requests complete in order, since there is one outstanding request total.

Test Plan:
- Reset, then port 0 writes addr 0x10, data 0xDEADBEEF, wstrb 1111 -> ready0 at T; mem_we=1, wa=0x10 at T+1; resp0_valid at T+2, err=0. A subsequent port 0 read of 0x10 -> resp0_rdata=0xDEADBEEF at accept+2.
- Partial write, wstrb=0010, data 0x0000AA00 to word holding 0x11223344 -> EXEC reads, MERGE writes 0x1122AA44; resp at T+3; read-back returns 0x1122AA44.
- Both ports hold valid continuously with reads -> grants alternate 0,1,0,1; each resp pulse arrives on the correct port only; no cycle has both ready.
- Out of range: addr=MEM_SIZE (0x1000), write -> mem_we never asserted; resp err=1, rdata=0. addr=0x0FFC read -> err=0.
- wstrb=0000 write -> no mem_we; resp at T+2.
- Reset asserted during MERGE -> mem_we drops immediately; no resp pulse; after release, port 0 wins a tie with port 1.
